// File: rtl/cpu_pkg.sv
// Integer-core constants and register index type shared by decode, writeback and the register file.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 64;
  localparam int REG_W = 6;
  localparam int NENT  = 1 << REG_W;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by decode reservations, cleared by writeback.
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_write,
  input  logic [REG_W-1:0] i_regno,
  input  logic             i_reserve,
  input  logic [REG_W-1:0] i_reserve_rd,
  input  logic             i_flush,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy
);

  logic [NENT-1:0] busy_q;
  logic [NENT-1:0] busy_d;
  logic [NENT-1:0] trackable;

  // x0 and indices past NREGS never become busy, so their lookups read 0.
  always_comb begin
    trackable = '0;
    for (int i = 0; i < NENT; i++) begin
      trackable[i] = (i != 0) && (i < NREGS);
    end
  end

  // Reserve is applied after release so a same-cycle reserve+write keeps the new writer pending.
  always_comb begin
    busy_d = busy_q;
    if (i_flush) begin
      busy_d = '0;
    end else begin
      if (i_write) begin
        busy_d[i_regno] = 1'b0;
      end
      if (i_reserve && trackable[i_reserve_rd]) begin
        busy_d[i_reserve_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A write landing this cycle is forwarded by the read bypass, so it is not a hazard.
  assign o_rs1_busy = busy_q[i_rs1] & ~(i_write & (i_regno == i_rs1));
  assign o_rs2_busy = busy_q[i_rs2] & ~(i_write & (i_regno == i_rs2));

endmodule

// File: rtl/regfile.sv
// Integer register file: two registered read ports with write bypass, plus the hazard scoreboard.
module regfile
  import cpu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_write,
  input  logic [XLEN-1:0]  i_data,
  input  logic [REG_W-1:0] i_regno,
  input  logic             i_rs1_en,
  input  logic [REG_W-1:0] i_rs1,
  input  logic             i_rs2_en,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_reserve,
  input  logic [REG_W-1:0] i_reserve_rd,
  input  logic             i_flush,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy
);

  logic [XLEN-1:0] regs_q [NENT];
  logic [XLEN-1:0] regs_d [NENT];
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [NENT-1:0] in_range;
  logic            wr_en;

  // Entries past NREGS are never written and stay 0, which gives out-of-range reads their 0.
  always_comb begin
    in_range = '0;
    for (int i = 0; i < NENT; i++) begin
      in_range[i] = (i < NREGS);
    end
  end

  assign wr_en = i_write & (i_regno != REG_ZERO) & in_range[i_regno];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[i_regno] = i_data;
    end
  end

  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (i_rs1_en) begin
      rs1_data_d = (wr_en && (i_regno == i_rs1)) ? i_data : regs_q[i_rs1];
    end
    if (i_rs2_en) begin
      rs2_data_d = (wr_en && (i_regno == i_rs2)) ? i_data : regs_q[i_rs2];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        regs_q[i] <= '0;
      end
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign o_rs1_data = rs1_data_q;
  assign o_rs2_data = rs2_data_q;

  regfile_scoreboard u_scoreboard (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_write      (i_write),
    .i_regno      (i_regno),
    .i_reserve    (i_reserve),
    .i_reserve_rd (i_reserve_rd),
    .i_flush      (i_flush),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .o_rs1_busy   (o_rs1_busy),
    .o_rs2_busy   (o_rs2_busy)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic against an array model.
module tb_regfile;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_en, rs1_en, rs2_en, rsv, flush;
  logic [31:0] w_data;
  logic [5:0]  w_reg, rs1, rs2, rsv_rd;
  logic [31:0] o_rs1_data, o_rs2_data;
  logic        o_rs1_busy, o_rs2_busy;

  regfile dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_write      (w_en),
    .i_data       (w_data),
    .i_regno      (w_reg),
    .i_rs1_en     (rs1_en),
    .i_rs1        (rs1),
    .i_rs2_en     (rs2_en),
    .i_rs2        (rs2),
    .i_reserve    (rsv),
    .i_reserve_rd (rsv_rd),
    .i_flush      (flush),
    .o_rs1_data   (o_rs1_data),
    .o_rs2_data   (o_rs2_data),
    .o_rs1_busy   (o_rs1_busy),
    .o_rs2_busy   (o_rs2_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [64];
  logic        m_busy [64];
  logic [31:0] m_rs1, m_rs2;

  task automatic idle();
    w_en = 0; w_data = '0; w_reg = '0;
    rs1_en = 0; rs1 = '0; rs2_en = 0; rs2 = '0;
    rsv = 0; rsv_rd = '0; flush = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_rs1 = '0;
    m_rs2 = '0;
  endtask

  function automatic logic exp_busy(logic [5:0] idx);
    return m_busy[idx] && !(w_en && (w_reg == idx));
  endfunction

  // Advance one clock edge, applying the architectural rules to the model.
  task automatic step();
    logic [31:0] n1, n2;
    n1 = m_rs1;
    n2 = m_rs2;
    if (rs1_en) n1 = (w_en && w_reg != 0 && w_reg == rs1) ? w_data : m_regs[rs1];
    if (rs2_en) n2 = (w_en && w_reg != 0 && w_reg == rs2) ? w_data : m_regs[rs2];
    @(posedge clk);
    if (w_en && w_reg != 0) m_regs[w_reg] = w_data;
    if (flush) begin
      for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
    end else begin
      if (w_en) m_busy[w_reg] = 1'b0;
      if (rsv && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
    end
    m_rs1 = n1;
    m_rs2 = n2;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_rs1_data !== 32'h0 || o_rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0/0", o_rs1_data, o_rs2_data);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rs1_en = 1; rs1 = 6'(i);
      rs2_en = 1; rs2 = 6'(63 - i);
      #1;
      checks++;
      if (o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy x%0d: got %b/%b want 0/0", i, o_rs1_busy, o_rs2_busy);
      end
      step();
      checks++;
      if (o_rs1_data !== 32'h0 || o_rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read x%0d: got %h/%h want 0/0", i, o_rs1_data, o_rs2_data);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    idle();
    w_en = 1; w_reg = 6'd5; w_data = 32'hDEADBEEF;
    step();
    @(negedge clk);
    idle();
    rs1_en = 1; rs1 = 6'd5;
    #1;
    checks++;
    if (o_rs1_data === 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_latency: got %h before the read edge, want previous value", o_rs1_data);
    end
    step();
    checks++;
    if (o_rs1_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_x5: got %h want deadbeef", o_rs1_data);
    end
    @(negedge clk);
    idle();
    rs1 = 6'd6;
    step();
    checks++;
    if (o_rs1_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_hold: got %h want deadbeef", o_rs1_data);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    w_en = 1; w_reg = 6'd7; w_data = 32'h12345678;
    rs2_en = 1; rs2 = 6'd7;
    step();
    checks++;
    if (o_rs2_data !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_x7: got %h want 12345678", o_rs2_data);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle();
    w_en = 1; w_reg = 6'd0; w_data = 32'hFFFFFFFF;
    rs1_en = 1; rs1 = 6'd0;
    step();
    checks++;
    if (o_rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass: got %h want 0", o_rs1_data);
    end
    @(negedge clk);
    idle();
    rs1_en = 1; rs1 = 6'd0;
    step();
    checks++;
    if (o_rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_read: got %h want 0", o_rs1_data);
    end
    @(negedge clk);
    idle();
    rsv = 1; rsv_rd = 6'd0;
    step();
    @(negedge clk);
    idle();
    rs1 = 6'd0;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL x0_busy: got %b want 0", o_rs1_busy);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    rsv = 1; rsv_rd = 6'd3;
    step();
    @(negedge clk);
    idle();
    rs1 = 6'd3;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_set_x3: got %b want 1", o_rs1_busy);
    end
    step();
    @(negedge clk);
    idle();
    rs1 = 6'd3; rs1_en = 1;
    w_en = 1; w_reg = 6'd3; w_data = 32'hA5A5_0003;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_wb_cycle_x3: got %b want 0", o_rs1_busy);
    end
    rsv = 1; rsv_rd = 6'd3;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_same_cycle_rsv: got %b want 0", o_rs1_busy);
    end
    step();
    @(negedge clk);
    idle();
    rs1 = 6'd3;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rsv_and_wb_x3: got %b want 1", o_rs1_busy);
    end
    checks++;
    if (o_rs1_data !== 32'hA5A5_0003) begin
      errors++;
      $display("FAIL bypass_x3: got %h want a5a50003", o_rs1_data);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle();
    rsv = 1; rsv_rd = 6'd4;
    step();
    @(negedge clk);
    rsv_rd = 6'd9;
    step();
    @(negedge clk);
    idle();
    rs1 = 6'd4; rs2 = 6'd9;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b1 || o_rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush_busy: got %b/%b want 1/1", o_rs1_busy, o_rs2_busy);
    end
    flush = 1; rsv = 1; rsv_rd = 6'd10;
    step();
    @(negedge clk);
    idle();
    rs1 = 6'd4; rs2 = 6'd9;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_x4_x9: got %b/%b want 0/0", o_rs1_busy, o_rs2_busy);
    end
    rs1 = 6'd10;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_drops_rsv_x10: got %b want 0", o_rs1_busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      w_en   = ($urandom_range(0, 2) == 0);
      w_reg  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      w_data = $urandom;
      rs1_en = ($urandom_range(0, 3) != 0);
      rs1    = 6'($urandom_range(0, 7));
      rs2_en = ($urandom_range(0, 3) != 0);
      rs2    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      rsv    = ($urandom_range(0, 2) == 0);
      rsv_rd = 6'($urandom_range(0, 7));
      flush  = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (o_rs1_busy !== exp_busy(rs1) || o_rs2_busy !== exp_busy(rs2)) begin
        errors++;
        $display("FAIL rand_busy cyc%0d: got %b/%b want %b/%b", n, o_rs1_busy, o_rs2_busy,
                 exp_busy(rs1), exp_busy(rs2));
      end
      step();
      checks++;
      if (o_rs1_data !== m_rs1 || o_rs2_data !== m_rs2) begin
        errors++;
        $display("FAIL rand_data cyc%0d: got %h/%h want %h/%h", n, o_rs1_data, o_rs2_data,
                 m_rs1, m_rs2);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    w_en = 1; w_reg = 6'd12; w_data = 32'hCAFE_F00D;
    rs2_en = 1; rs2 = 6'd12;
    rsv = 1; rsv_rd = 6'd13;
    step();
    @(negedge clk);
    idle();
    rs1 = 6'd13; rs2 = 6'd12;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b1 || o_rs2_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL pre_reset_state: got busy %b data %h want 1 cafef00d", o_rs1_busy, o_rs2_data);
    end
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (o_rs1_data !== 32'h0 || o_rs2_data !== 32'h0 || o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%h busy %b/%b want 0/0 0/0", o_rs1_data, o_rs2_data,
               o_rs1_busy, o_rs2_busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    rs1_en = 1; rs1 = 6'd13;
    rs2_en = 1; rs2 = 6'd12;
    #1;
    checks++;
    if (o_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_busy: got %b want 0", o_rs1_busy);
    end
    step();
    checks++;
    if (o_rs2_data !== 32'h0 || o_rs2_data !== m_rs2) begin
      errors++;
      $display("FAIL post_reset_read_x12: got %h want 0", o_rs2_data);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
